// File: rtl/reg_bank.sv
// Register bank with write, increment/decrement, a tri-state read port, an
// always-driven read port and a flattened monitor of every register.
module reg_bank #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
) (
    input  logic                            clk,
    input  logic                            res,
    input  logic                            save_enable,
    input  logic [ADDR_W-1:0]               save_addr,
    input  logic [WIDTH-1:0]                save_byte,
    input  logic                            inc_enable,
    input  logic                            dec_enable,
    input  logic [ADDR_W-1:0]               op_addr,
    input  logic                            load_enable,
    input  logic [ADDR_W-1:0]               load_addr,
    input  logic [ADDR_W-1:0]               const_addr,
    output logic [WIDTH-1:0]                tri_output,
    output logic [WIDTH-1:0]                constant_output,
    output logic [(2**ADDR_W)*WIDTH-1:0]    monitor_signal,
    output logic                            wrap_flag
);

    localparam int NREG = 2**ADDR_W;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic             wrap_q;
    logic             wrap_d;
    logic             op_eff;

    // A write to the same register wins; inc and dec together cancel out.
    assign op_eff = (inc_enable ^ dec_enable) &&
                    !(save_enable && (save_addr == op_addr));

    always_comb begin
        regs_d = regs_q;
        wrap_d = 1'b0;
        if (op_eff) begin
            if (inc_enable) begin
                regs_d[op_addr] = regs_q[op_addr] + WIDTH'(1);
                wrap_d          = &regs_q[op_addr];
            end else begin
                regs_d[op_addr] = regs_q[op_addr] - WIDTH'(1);
                wrap_d          = ~|regs_q[op_addr];
            end
        end
        if (save_enable) begin
            regs_d[save_addr] = save_byte;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wrap_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            wrap_q <= wrap_d;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_mon
        assign monitor_signal[g*WIDTH +: WIDTH] = regs_q[g];
    end

    assign tri_output      = load_enable ? regs_q[load_addr] : {WIDTH{1'bz}};
    assign constant_output = regs_q[const_addr];
    assign wrap_flag       = wrap_q;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: default 8x4 instance plus a 16x8 instance.
module tb_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fails   = 0;

    // Default-parameter instance
    logic        res, save_enable, inc_enable, dec_enable, load_enable;
    logic [1:0]  save_addr, op_addr, load_addr, const_addr;
    logic [7:0]  save_byte;
    wire  [7:0]  tri_bus;
    logic [7:0]  constant_output;
    logic [31:0] monitor_signal;
    logic        wrap_flag;

    // Pull-ups make an undriven bus read as all-ones in any simulator.
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (tri_bus[i]);
    end

    reg_bank u_dut (
        .clk(clk), .res(res),
        .save_enable(save_enable), .save_addr(save_addr), .save_byte(save_byte),
        .inc_enable(inc_enable), .dec_enable(dec_enable), .op_addr(op_addr),
        .load_enable(load_enable), .load_addr(load_addr), .const_addr(const_addr),
        .tri_output(tri_bus), .constant_output(constant_output),
        .monitor_signal(monitor_signal), .wrap_flag(wrap_flag)
    );

    // Wide instance
    logic         res16, save16, inc16, dec16, load16;
    logic [2:0]   saddr16, oaddr16, laddr16, caddr16;
    logic [15:0]  sbyte16;
    wire  [15:0]  tri16;
    logic [15:0]  const16;
    logic [127:0] mon16;
    logic         wrap16;

    reg_bank #(.WIDTH(16), .ADDR_W(3)) u_dut16 (
        .clk(clk), .res(res16),
        .save_enable(save16), .save_addr(saddr16), .save_byte(sbyte16),
        .inc_enable(inc16), .dec_enable(dec16), .op_addr(oaddr16),
        .load_enable(load16), .load_addr(laddr16), .const_addr(caddr16),
        .tri_output(tri16), .constant_output(const16),
        .monitor_signal(mon16), .wrap_flag(wrap16)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        res = 1'b1; save_enable = 1'b1; save_addr = 2'd2; save_byte = 8'hFF;
        inc_enable = 1'b1; dec_enable = 1'b0; op_addr = 2'd0;
        load_enable = 1'b1; load_addr = 2'd2; const_addr = 2'd2;
        res16 = 1'b1; save16 = 1'b0; saddr16 = 3'd0; sbyte16 = 16'h0;
        inc16 = 1'b0; dec16 = 1'b0; oaddr16 = 3'd0;
        load16 = 1'b0; laddr16 = 3'd0; caddr16 = 3'd0;

        // Reset holds through an edge even with strobes active
        tick();
        chk("rst_monitor", monitor_signal, 0);
        chk("rst_const", constant_output, 0);
        chk("rst_wrap", wrap_flag, 0);
        chk("rst_tri_load", tri_bus, 0);
        chk("rst_mon16", mon16, 0);

        save_enable = 1'b0; inc_enable = 1'b0; load_enable = 1'b0;
        res = 1'b0; res16 = 1'b0;

        // Write 0xA5 to reg 2; no write-through before the edge
        save_enable = 1'b1; save_addr = 2'd2; save_byte = 8'hA5;
        #1;
        chk("no_bypass", constant_output, 8'h00);
        tick();
        save_enable = 1'b0;
        chk("const_a5", constant_output, 8'hA5);
        chk("tri_z", tri_bus, 8'hFF);
        load_enable = 1'b1; load_addr = 2'd2;
        #1;
        chk("tri_a5", tri_bus, 8'hA5);
        load_addr = 2'd0;
        #1;
        chk("tri_r0", tri_bus, 8'h00);
        load_enable = 1'b0;

        // Increment wrap on reg 1
        save_enable = 1'b1; save_addr = 2'd1; save_byte = 8'hFF;
        tick();
        save_enable = 1'b0; inc_enable = 1'b1; op_addr = 2'd1;
        tick();
        chk("inc_wrap_val", monitor_signal[15:8], 8'h00);
        chk("inc_wrap_flag", wrap_flag, 1);
        tick();
        inc_enable = 1'b0;
        chk("inc2_val", monitor_signal[15:8], 8'h01);
        chk("inc2_flag", wrap_flag, 0);

        // Decrement wrap on reg 0, then inc+dec cancels
        dec_enable = 1'b1; op_addr = 2'd0;
        tick();
        chk("dec_wrap_val", monitor_signal[7:0], 8'hFF);
        chk("dec_wrap_flag", wrap_flag, 1);
        inc_enable = 1'b1;
        tick();
        inc_enable = 1'b0; dec_enable = 1'b0;
        chk("incdec_val", monitor_signal[7:0], 8'hFF);
        chk("incdec_flag", wrap_flag, 0);

        // Write priority over increment on the same register
        save_enable = 1'b1; save_addr = 2'd3; save_byte = 8'hFF;
        tick();
        save_byte = 8'h10; inc_enable = 1'b1; op_addr = 2'd3;
        tick();
        save_enable = 1'b0; inc_enable = 1'b0;
        chk("prio_val", monitor_signal[31:24], 8'h10);
        chk("prio_flag", wrap_flag, 0);

        // Write and increment on different registers in one cycle
        save_enable = 1'b1; save_addr = 2'd1; save_byte = 8'h05;
        tick();
        save_addr = 2'd0; save_byte = 8'h22; inc_enable = 1'b1; op_addr = 2'd1;
        tick();
        save_enable = 1'b0; inc_enable = 1'b0;
        chk("par_monitor", monitor_signal, 32'h10A5_0622);
        tick();
        chk("idle_hold", monitor_signal, 32'h10A5_0622);
        chk("idle_wrap", wrap_flag, 0);

        // Asynchronous reset mid-cycle
        #3;
        res = 1'b1;
        #1;
        chk("async_monitor", monitor_signal, 0);
        chk("async_const", constant_output, 0);
        tick();
        res = 1'b0;
        chk("async_hold", monitor_signal, 0);

        // Wide instance: wrap of 0xFFFF on register 7
        save16 = 1'b1; saddr16 = 3'd7; sbyte16 = 16'hFFFF;
        tick();
        chk("w16_load", mon16[127:112], 16'hFFFF);
        save16 = 1'b0; inc16 = 1'b1; oaddr16 = 3'd7;
        tick();
        inc16 = 1'b0;
        chk("w16_wrap_val", mon16[127:112], 16'h0000);
        chk("w16_wrap_flag", wrap16, 1);
        save16 = 1'b1; saddr16 = 3'd7; sbyte16 = 16'h1234;
        tick();
        save16 = 1'b0; caddr16 = 3'd7;
        #1;
        chk("w16_mon_full", mon16, {16'h1234, 112'h0});
        chk("w16_const", const16, 16'h1234);
        chk("w16_flag_clr", wrap16, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of every register.
REQ-002 SHALL have parameter ADDR_W, default 2: address width; register count NREG = 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port res  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port save_enable  input  1  write strobe.
REQ-006 SHALL have port save_addr  input  ADDR_W  write target register.
REQ-007 SHALL have port save_byte  input  WIDTH  write data.
REQ-008 SHALL have port inc_enable  input  1  increment request for register op_addr.
REQ-009 SHALL have port dec_enable  input  1  decrement request for register op_addr.
REQ-010 SHALL have port op_addr  input  ADDR_W  increment/decrement target register.
REQ-011 SHALL have port load_enable  input  1  drive tri_output.
REQ-012 SHALL have port load_addr  input  ADDR_W  register selected onto tri_output.
REQ-013 SHALL have port const_addr  input  ADDR_W  register selected onto constant_output.
REQ-014 SHALL have port tri_output  output  WIDTH  three-state bus output.
REQ-015 SHALL have port constant_output  output  WIDTH  always-driven output.
REQ-016 SHALL have port monitor_signal  output  NREG*WIDTH  all registers flattened; register i at bits [i*WIDTH +: WIDTH].
REQ-017 SHALL have port wrap_flag  output  1  registered pulse on increment/decrement wrap-around.

Function
REQ-018 SHALL hold NREG registers of WIDTH bits each.
REQ-019 SHALL, on a rising clk edge with save_enable=1, load save_byte into register save_addr.
REQ-020 SHALL, on a rising clk edge with inc_enable=1 and dec_enable=0, set register op_addr to its value +1 modulo 2**WIDTH.
REQ-021 SHALL, on a rising clk edge with dec_enable=1 and inc_enable=0, set register op_addr to its value -1 modulo 2**WIDTH.
REQ-022 SHALL treat inc_enable=1 with dec_enable=1 as no operation on op_addr; wrap_flag is not set.
REQ-023 SHALL, when save_enable is active and save_addr equals op_addr, give the write priority: save_byte is stored, the increment/decrement is discarded, and wrap_flag is not set.
REQ-024 SHALL, when save_addr differs from op_addr, perform the write and the increment/decrement in the same cycle.
REQ-025 SHALL set wrap_flag to 1 for exactly the cycle after an edge where an effective increment took a register from all-ones to 0, or an effective decrement took it from 0 to all-ones; otherwise wrap_flag is 0 after that edge.
REQ-026 SHALL drive tri_output combinationally with register load_addr when load_enable=1, and all-Z when load_enable=0.
REQ-027 SHALL drive constant_output combinationally with register const_addr at all times.
REQ-028 SHALL drive monitor_signal combinationally with the current contents of all registers.
REQ-029 SHALL present pre-edge register values on all read outputs until the edge that updates them; no write-through bypass.
REQ-030 SHALL leave registers unchanged in cycles with no write and no effective increment/decrement.

Reset
REQ-031 SHALL, while res=1, immediately clear all registers to 0 and clear wrap_flag to 0, independent of clk.
REQ-032 SHALL ignore save_enable, inc_enable and dec_enable while res=1; operation resumes on the first rising clk edge after res falls.
REQ-033 SHALL, during reset, drive constant_output=0 and monitor_signal=0, and drive tri_output=0 if load_enable=1, otherwise Z.

Verification
REQ-034 SHALL cover: with defaults, assert res, then write 0xA5 to reg 2 -> constant_output=0xA5 with const_addr=2 after the edge; tri_output=Z with load_enable=0; tri_output=0xA5 with load_enable=1 and load_addr=2.
REQ-035 SHALL cover: write 0xFF to reg 1, then inc_enable with op_addr=1 -> reg 1 reads 0x00 and wrap_flag=1 for one cycle; a second increment gives 0x01 and wrap_flag=0.
REQ-036 SHALL cover: decrement reg 0 from its reset value 0 -> 0xFF and wrap_flag=1; then inc_enable and dec_enable together -> value stays 0xFF.
REQ-037 SHALL cover: in the same cycle, save_enable to reg 3 with 0x10 and inc_enable on reg 3 holding 0xFF -> reg 3 = 0x10 and wrap_flag=0; then write reg 0 = 0x22 while incrementing reg 1 from 0x05 -> reg 0 = 0x22 and reg 1 = 0x06.
REQ-038 SHALL cover: assert res asynchronously between edges while registers are nonzero -> monitor_signal=0 immediately, without waiting for a clk edge.
REQ-039 SHALL cover: WIDTH=16, ADDR_W=3 -> increment of 0xFFFF wraps to 0x0000 with wrap_flag=1, and register 7 appears at monitor_signal[127:112].
